// File: rtl/screen_buf_arbiter_pkg.sv
// Shared screen geometry and arbiter FSM encoding for the screen buffer arbiter.
// The screen dimensions below are the ones the VDU is built for.
package screen_buf_arbiter_pkg;

  localparam int SCREEN_ADDR_W = 14;
  localparam int CHAR_W        = 8;
  localparam int SCREEN_COLS   = 80;
  localparam int SCREEN_ROWS   = 60;
  localparam int SCREEN_DEPTH  = SCREEN_COLS * SCREEN_ROWS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_PEND = 2'd1,
    ST_RD_CAPT = 2'd2,
    ST_CLEAR   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/screen_buf_arbiter_clear.sv
// Clear-screen engine: holds the fill character and walks the buffer one cell per step.
// The counter stops on the last cell, so it never wraps back to address 0.
module screen_clear_engine
  import screen_buf_arbiter_pkg::*;
#(
  parameter int ADDR_W = SCREEN_ADDR_W,
  parameter int DATA_W = CHAR_W,
  parameter int DEPTH  = SCREEN_DEPTH
) (
  input  logic              pixel_clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_char,
  input  logic              start,
  input  logic              step,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] fill_char,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  assign done = step && busy && (addr == LAST_ADDR);

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      addr      <= '0;
      fill_char <= '0;
    end else begin
      if (load) begin
        fill_char <= load_char;
      end
      if (start) begin
        addr <= '0;
        busy <= 1'b1;
      end else if (step && busy) begin
        if (addr == LAST_ADDR) begin
          busy <= 1'b0;
        end else begin
          addr <= addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/screen_buf_arbiter.sv
// Screen buffer arbiter: display reads own every busy slot; CPU writes (posted), CPU reads
// and the clear engine share the free (blanking) slots in that priority order.
module screen_buf_arbiter
  import screen_buf_arbiter_pkg::*;
#(
  parameter int ADDR_W = SCREEN_ADDR_W,
  parameter int DATA_W = CHAR_W,
  parameter int DEPTH  = SCREEN_DEPTH
) (
  input  logic              pixel_clk,
  input  logic              rst_n,
  input  logic              vdu_rden,
  input  logic [ADDR_W-1:0] vdu_addr,
  output logic [DATA_W-1:0] vdu_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_char,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q,
  output arb_state_e        dbg_state
);

  // CPU handshake: cpu_req (with cpu_we/addr/wdata) is held until a one-cycle cpu_ack;
  // a request is taken only in IDLE, outside a clear, and never in a cycle where cpu_ack=1.
  arb_state_e        state_q, state_d;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              clr_pend;

  logic              req_ok, wr_acc, rd_acc, rd_fwd, rd_go;
  logic              clr_req_ok, clr_go;
  logic              wb_retire, clr_step, rd_issue, clr_done;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_fill;

  assign vdu_data  = ram_q;
  assign dbg_state = state_q;

  assign req_ok = cpu_req && !cpu_ack && (state_q == ST_IDLE) && !clr_busy && !clr_pend;
  assign wr_acc = req_ok && cpu_we && !wb_valid;
  assign rd_acc = req_ok && !cpu_we;
  assign rd_fwd = rd_acc && wb_valid && (wb_addr == cpu_addr);
  assign rd_go  = rd_acc && !rd_fwd;

  // A clear requested while a RAM read is in flight waits in clr_pend until IDLE.
  assign clr_req_ok = clr_start && !clr_busy && !clr_pend;
  assign clr_go     = (state_q == ST_IDLE) && (clr_pend || clr_req_ok) && !rd_go;

  always_comb begin
    ram_addr  = vdu_addr;
    ram_rden  = 1'b0;
    ram_wren  = 1'b0;
    ram_wdata = wb_data;
    wb_retire = 1'b0;
    clr_step  = 1'b0;
    rd_issue  = 1'b0;
    if (vdu_rden) begin
      ram_rden = 1'b1;
    end else if (wb_valid) begin
      ram_addr  = wb_addr;
      ram_wren  = 1'b1;
      wb_retire = 1'b1;
    end else if (clr_busy) begin
      ram_addr  = clr_addr;
      ram_wren  = 1'b1;
      ram_wdata = clr_fill;
      clr_step  = 1'b1;
    end else if (state_q == ST_RD_PEND) begin
      ram_addr = rd_addr;
      ram_rden = 1'b1;
      rd_issue = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_go) begin
          state_d = ST_CLEAR;
        end else if (rd_go) begin
          state_d = ST_RD_PEND;
        end
      end
      ST_RD_PEND: if (rd_issue) state_d = ST_RD_CAPT;
      ST_RD_CAPT: state_d = ST_IDLE;
      ST_CLEAR:   if (clr_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      rd_addr   <= '0;
      clr_pend  <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      state_q <= state_d;
      cpu_ack <= wr_acc || rd_fwd || (state_q == ST_RD_CAPT);
      if (rd_fwd) begin
        cpu_rdata <= wb_data;
      end else if (state_q == ST_RD_CAPT) begin
        cpu_rdata <= ram_q;
      end
      if (wr_acc) begin
        wb_valid <= 1'b1;
        wb_addr  <= cpu_addr;
        wb_data  <= cpu_wdata;
      end else if (wb_retire) begin
        wb_valid <= 1'b0;
      end
      if (rd_go) begin
        rd_addr <= cpu_addr;
      end
      if (clr_go) begin
        clr_pend <= 1'b0;
      end else if (clr_req_ok) begin
        clr_pend <= 1'b1;
      end
    end
  end

  screen_clear_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_clear (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .load      (clr_req_ok),
    .load_char (clr_char),
    .start     (clr_go),
    .step      (clr_step),
    .busy      (clr_busy),
    .addr      (clr_addr),
    .fill_char (clr_fill),
    .done      (clr_done)
  );

endmodule

// File: tb/tb_screen_buf_arbiter.sv
// Directed bench for screen_buf_arbiter with a behavioural 1-cycle-latency screen RAM.
module tb_screen_buf_arbiter;
  import screen_buf_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vdu_rden;
  logic [13:0] vdu_addr;
  logic [7:0]  vdu_data;
  logic        cpu_req, cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        clr_start;
  logic [7:0]  clr_char;
  logic        clr_busy;
  logic [13:0] ram_addr;
  logic        ram_rden, ram_wren;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_q;
  arb_state_e  dbg_state;

  logic [7:0]  mem [0:16383];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    if (ram_rden) ram_q <= mem[ram_addr];
  end

  screen_buf_arbiter dut (
    .pixel_clk (clk),
    .rst_n     (rst_n),
    .vdu_rden  (vdu_rden),
    .vdu_addr  (vdu_addr),
    .vdu_data  (vdu_data),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .clr_start (clr_start),
    .clr_char  (clr_char),
    .clr_busy  (clr_busy),
    .ram_addr  (ram_addr),
    .ram_rden  (ram_rden),
    .ram_wren  (ram_wren),
    .ram_wdata (ram_wdata),
    .ram_q     (ram_q),
    .dbg_state (dbg_state)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({clr_busy, cpu_ack, cpu_rdata, ram_wren, ram_rden, dbg_state} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, ST_IDLE}) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b ack=%b rdata=%h wren=%b rden=%b st=%0d, expected all zero/IDLE",
               clr_busy, cpu_ack, cpu_rdata, ram_wren, ram_rden, dbg_state);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset_mid_clear();
    int nw;
    clr_char  = 8'h33;
    clr_start = 1'b1;
    next_cycle();
    clr_start = 1'b0;
    repeat (10) next_cycle();
    @(negedge clk);
    n_checks++;
    if ({clr_busy, ram_wren, ram_wdata} !== {1'b1, 1'b1, 8'h33}) begin
      n_fail++;
      $display("FAIL clear_running: busy=%b wren=%b wdata=%h, expected 1 1 33", clr_busy, ram_wren, ram_wdata);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({clr_busy, cpu_ack, ram_wren, dbg_state} !== {1'b0, 1'b0, 1'b0, ST_IDLE}) begin
      n_fail++;
      $display("FAIL reset_mid_clear: busy=%b ack=%b wren=%b st=%0d, expected 0 0 0 IDLE",
               clr_busy, cpu_ack, ram_wren, dbg_state);
    end
    next_cycle();
    rst_n = 1'b1;
    nw = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_wren || clr_busy) nw++;
      next_cycle();
    end
    n_checks++;
    if (nw !== 0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: %0d busy/write cycles, expected 0", nw);
    end
  endtask

  task automatic test_write_during_display();
    int ack_cyc, n_ack, slot_err;
    ack_cyc  = -1;
    n_ack    = 0;
    slot_err = 0;
    vdu_rden = 1'b1;
    for (int i = 0; i < 800; i++) begin
      vdu_addr = 14'(i * 7 + 3);
      if (i == 5) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0010; cpu_wdata = 8'hC3;
      end
      @(negedge clk);
      if ({ram_rden, ram_wren, ram_addr} !== {1'b1, 1'b0, vdu_addr}) slot_err++;
      if (cpu_ack) begin
        n_ack++;
        if (ack_cyc < 0) ack_cyc = i;
      end
      next_cycle();
      if (ack_cyc >= 0) cpu_req = 1'b0;
    end
    n_checks++;
    if (slot_err !== 0) begin
      n_fail++;
      $display("FAIL display_slot_track: %0d bad cycles, expected 0", slot_err);
    end
    n_checks++;
    if (ack_cyc !== 6 || n_ack !== 1) begin
      n_fail++;
      $display("FAIL write_ack_latency: ack at %0d (%0d acks), expected cycle 6 (1 ack)", ack_cyc, n_ack);
    end
    vdu_rden = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ram_wren, ram_addr, ram_wdata} !== {1'b1, 14'h0010, 8'hC3}) begin
      n_fail++;
      $display("FAIL first_free_retire: wren=%b addr=%h data=%h, expected 1 0010 c3", ram_wren, ram_addr, ram_wdata);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (ram_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL retire_once: wren=%b, expected 0", ram_wren);
    end
    next_cycle();
  endtask

  task automatic test_read_forward();
    vdu_rden = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0123; cpu_wdata = 8'h41;
    for (int i = 0; i < 4; i++) begin
      vdu_addr = 14'(100 + i);
      @(negedge clk);
      n_checks++;
      if ({ram_rden, ram_wren, ram_addr} !== {1'b1, 1'b0, vdu_addr}) begin
        n_fail++;
        $display("FAIL fwd_slot_%0d: rden=%b wren=%b addr=%h, expected 1 0 %h", i, ram_rden, ram_wren, ram_addr, vdu_addr);
      end
      n_checks++;
      case (i)
        0, 2: if (cpu_ack !== 1'b0) begin
          n_fail++;
          $display("FAIL fwd_no_ack_%0d: ack=%b, expected 0", i, cpu_ack);
        end
        1: if (cpu_ack !== 1'b1) begin
          n_fail++;
          $display("FAIL fwd_write_ack: ack=%b, expected 1", cpu_ack);
        end
        default: if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h41}) begin
          n_fail++;
          $display("FAIL fwd_read_data: ack=%b rdata=%h, expected 1 41", cpu_ack, cpu_rdata);
        end
      endcase
      next_cycle();
      if (i == 1) cpu_we = 1'b0;
      if (i == 3) cpu_req = 1'b0;
    end
    vdu_rden = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ram_wren, ram_rden, ram_addr, ram_wdata} !== {1'b1, 1'b0, 14'h0123, 8'h41}) begin
      n_fail++;
      $display("FAIL fwd_retire: wren=%b rden=%b addr=%h data=%h, expected 1 0 0123 41",
               ram_wren, ram_rden, ram_addr, ram_wdata);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({ram_wren, ram_rden, dbg_state} !== {1'b0, 1'b0, ST_IDLE}) begin
      n_fail++;
      $display("FAIL fwd_no_ram_read: wren=%b rden=%b st=%0d, expected 0 0 IDLE", ram_wren, ram_rden, dbg_state);
    end
    next_cycle();
  endtask

  task automatic test_read_latency();
    vdu_rden = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0200; cpu_wdata = 8'h5A;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({cpu_ack, ram_wren, ram_addr, ram_wdata} !== {1'b1, 1'b1, 14'h0200, 8'h5A}) begin
      n_fail++;
      $display("FAIL preload_write: ack=%b wren=%b addr=%h data=%h, expected 1 1 0200 5a",
               cpu_ack, ram_wren, ram_addr, ram_wdata);
    end
    next_cycle();
    cpu_req = 1'b0;
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      case (i)
        0: if ({ram_rden, ram_wren, cpu_ack} !== 3'b000) begin
          n_fail++;
          $display("FAIL rd_req_cycle: rden=%b wren=%b ack=%b, expected 0 0 0", ram_rden, ram_wren, cpu_ack);
        end
        1: if ({ram_rden, ram_addr, cpu_ack, dbg_state} !== {1'b1, 14'h0200, 1'b0, ST_RD_PEND}) begin
          n_fail++;
          $display("FAIL rd_issue: rden=%b addr=%h ack=%b st=%0d, expected 1 0200 0 RD_PEND",
                   ram_rden, ram_addr, cpu_ack, dbg_state);
        end
        2: if ({ram_rden, cpu_ack, dbg_state} !== {1'b0, 1'b0, ST_RD_CAPT}) begin
          n_fail++;
          $display("FAIL rd_capture: rden=%b ack=%b st=%0d, expected 0 0 RD_CAPT", ram_rden, cpu_ack, dbg_state);
        end
        default: if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h5A}) begin
          n_fail++;
          $display("FAIL rd_data: ack=%b rdata=%h, expected 1 5a", cpu_ack, cpu_rdata);
        end
      endcase
      next_cycle();
      if (i == 3) cpu_req = 1'b0;
    end
    next_cycle();
  endtask

  task automatic test_wb_stall();
    vdu_rden = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0300; cpu_wdata = 8'h11;
    for (int i = 0; i < 10; i++) begin
      if (i == 7) vdu_rden = 1'b0;
      @(negedge clk);
      n_checks++;
      case (i)
        1: if (cpu_ack !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_first_ack: ack=%b, expected 1", cpu_ack);
        end
        7: if ({cpu_ack, ram_wren, ram_addr, ram_wdata} !== {1'b0, 1'b1, 14'h0300, 8'h11}) begin
          n_fail++;
          $display("FAIL stall_retire_a: ack=%b wren=%b addr=%h data=%h, expected 0 1 0300 11",
                   cpu_ack, ram_wren, ram_addr, ram_wdata);
        end
        9: if ({cpu_ack, ram_wren, ram_addr, ram_wdata} !== {1'b1, 1'b1, 14'h0301, 8'h22}) begin
          n_fail++;
          $display("FAIL stall_retire_b: ack=%b wren=%b addr=%h data=%h, expected 1 1 0301 22",
                   cpu_ack, ram_wren, ram_addr, ram_wdata);
        end
        default: if (cpu_ack !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_no_ack_%0d: ack=%b, expected 0", i, cpu_ack);
        end
      endcase
      next_cycle();
      if (i == 1) begin
        cpu_addr = 14'h0301; cpu_wdata = 8'h22;
      end
      if (i == 9) cpu_req = 1'b0;
    end
    next_cycle();
  endtask

  task automatic test_clear();
    int n_wr, wr_err, last_wr, done_cyc, ack_cyc;
    logic busy_1;
    n_wr = 0; wr_err = 0; last_wr = -1; done_cyc = -1; ack_cyc = -1; busy_1 = 1'b0;
    clr_char = 8'h20;
    for (int i = 0; i < 12000; i++) begin
      vdu_rden  = (i % 2) == 1;
      vdu_addr  = 14'(i);
      clr_start = (i == 0);
      if (i == 100) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h1000; cpu_wdata = 8'h77;
      end
      @(negedge clk);
      if (i == 1) busy_1 = clr_busy;
      if (clr_busy && ram_wren) begin
        if (ram_addr !== 14'(n_wr) || ram_wdata !== 8'h20) wr_err++;
        n_wr++;
        last_wr = i;
      end
      if (i > 0 && !clr_busy && done_cyc < 0) done_cyc = i;
      if (cpu_ack && ack_cyc < 0) ack_cyc = i;
      next_cycle();
      if (ack_cyc >= 0) cpu_req = 1'b0;
      if (ack_cyc >= 0 && i > ack_cyc + 2) break;
    end
    clr_start = 1'b0;
    n_checks++;
    if (busy_1 !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_busy_rise: busy=%b one cycle after start, expected 1", busy_1);
    end
    n_checks++;
    if (n_wr !== 4800 || wr_err !== 0) begin
      n_fail++;
      $display("FAIL clear_writes: %0d writes, %0d bad, expected 4800 writes, 0 bad", n_wr, wr_err);
    end
    n_checks++;
    if (done_cyc !== last_wr + 1) begin
      n_fail++;
      $display("FAIL clear_busy_drop: dropped at %0d, expected %0d", done_cyc, last_wr + 1);
    end
    n_checks++;
    if (ack_cyc !== done_cyc + 1) begin
      n_fail++;
      $display("FAIL clear_cpu_held: ack at %0d, expected %0d", ack_cyc, done_cyc + 1);
    end
    n_checks++;
    if ({mem[0], mem[4799], mem[16'h1000]} !== {8'h20, 8'h20, 8'h77}) begin
      n_fail++;
      $display("FAIL clear_contents: mem0=%h mem4799=%h mem1000=%h, expected 20 20 77",
               mem[0], mem[4799], mem[16'h1000]);
    end
    vdu_rden = 1'b0;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int n_wr, wr_err, quiet_err;
    n_wr = 0; wr_err = 0; quiet_err = 0;
    vdu_rden = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0005; cpu_wdata = 8'hAB;
    clr_start = 1'b1; clr_char = 8'h2E;
    @(negedge clk);
    n_checks++;
    if (ram_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept_cycle: wren=%b, expected 0", ram_wren);
    end
    next_cycle();
    clr_start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cpu_ack, clr_busy, ram_wren, ram_addr, ram_wdata} !== {1'b1, 1'b1, 1'b1, 14'h0005, 8'hAB}) begin
      n_fail++;
      $display("FAIL b2b_wb_first: ack=%b busy=%b wren=%b addr=%h data=%h, expected 1 1 1 0005 ab",
               cpu_ack, clr_busy, ram_wren, ram_addr, ram_wdata);
    end
    next_cycle();
    cpu_req = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (i == 1) begin
        clr_start = 1'b1; clr_char = 8'h55;
      end else begin
        clr_start = 1'b0;
      end
      @(negedge clk);
      if (clr_busy && ram_wren) begin
        if (ram_addr !== 14'(n_wr) || ram_wdata !== 8'h2E) wr_err++;
        n_wr++;
      end
      next_cycle();
      if (!clr_busy) break;
    end
    n_checks++;
    if (n_wr !== 4800 || wr_err !== 0) begin
      n_fail++;
      $display("FAIL b2b_clear_writes: %0d writes, %0d bad, expected 4800 writes, 0 bad", n_wr, wr_err);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (clr_busy || ram_wren) quiet_err++;
      next_cycle();
    end
    n_checks++;
    if (quiet_err !== 0) begin
      n_fail++;
      $display("FAIL b2b_restart_ignored: %0d busy cycles after clear, expected 0", quiet_err);
    end
  endtask

  initial begin
    rst_n = 1'b0; vdu_rden = 1'b0; vdu_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    clr_start = 1'b0; clr_char = '0;
    test_reset();
    test_reset_mid_clear();
    test_write_during_display();
    test_read_forward();
    test_read_latency();
    test_wb_stall();
    test_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

endmodule
